// File: rtl/clock_divider_prog_if.sv
// rtl/clock_divider_prog_if.sv - control/status bundle for the programmable clock divider
interface clock_divider_prog_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic             sync_clr;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic             tick;
  logic             clk_out;
  logic             div_busy;
  logic             div_err;

  modport master (
    output en, sync_clr, div_load, div_val,
    input  tick, clk_out, div_busy, div_err
  );

  modport slave (
    input  en, sync_clr, div_load, div_val,
    output tick, clk_out, div_busy, div_err
  );
endinterface

// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - runtime-programmable tick/square-wave divider
// Optional CLKDIV_SIM_FAST_EN shrinks the reset divisor by 1000 (min 1) for fast simulation.
module clock_divider_prog #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int TICK_HZ     = 1,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_divider_prog_if.slave  bus
);

  localparam int DIV_DEFAULT = CLK_FREQ_HZ / TICK_HZ;
`ifdef CLKDIV_SIM_FAST_EN
  localparam int DIV_RESET_I = (DIV_DEFAULT / 1000 < 1) ? 1 : DIV_DEFAULT / 1000;
`else
  localparam int DIV_RESET_I = DIV_DEFAULT;
`endif
  localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(DIV_RESET_I);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_pend;
  logic             pend;
  logic             tick_q;
  logic             clk_out_q;
  logic             div_err_q;

  logic [CNT_W-1:0] div_last;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_thresh;
  logic             wrap;
  logic             load_ok;
  logic             load_zero;
  logic             apply;

  always_comb begin
    div_last  = div_q - CNT_W'(1);
    wrap      = (cnt == div_last);
    cnt_inc   = wrap ? '0 : cnt + CNT_W'(1);
    // clk_out goes high once the count reaches ceil(div/2), giving low-then-high halves
    hi_thresh = div_q - (div_q >> 1);
    load_ok   = bus.div_load && (bus.div_val != '0);
    load_zero = bus.div_load && (bus.div_val == '0);
    // A pending divisor only takes effect at a period boundary: wrap, clear, or while stopped
    apply     = pend && (bus.sync_clr || !bus.en || wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      div_q     <= DIV_RESET;
      div_pend  <= '0;
      pend      <= 1'b0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      div_err_q <= load_zero;

      // A new load on the apply edge re-arms pend; div_q still takes the older pending value
      if (load_ok) begin
        div_pend <= bus.div_val;
        pend     <= 1'b1;
      end else if (apply) begin
        pend     <= 1'b0;
      end

      if (apply) begin
        div_q <= div_pend;
      end

      if (bus.sync_clr) begin
        cnt       <= '0;
        tick_q    <= 1'b0;
        clk_out_q <= 1'b0;
      end else if (bus.en) begin
        cnt       <= cnt_inc;
        tick_q    <= wrap;
        clk_out_q <= (cnt_inc >= hi_thresh);
      end else begin
        tick_q <= 1'b0;
        if (apply) begin
          cnt       <= '0;
          clk_out_q <= 1'b0;
        end
      end
    end
  end

  assign bus.tick     = tick_q;
  assign bus.clk_out  = clk_out_q;
  assign bus.div_busy = pend;
  assign bus.div_err  = div_err_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - directed self-checking bench for clock_divider_prog
module tb_clock_divider_prog;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  clock_divider_prog_if #(.CNT_W(CNT_W)) dif ();

  clock_divider_prog #(
    .CLK_FREQ_HZ(1000),
    .TICK_HZ    (100),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.en = 1'b0;
    dif.sync_clr = 1'b0;
    dif.div_load = 1'b0;
    dif.div_val = '0;
    step();
    step();
    checks++; if (dif.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", dif.tick); end
    checks++; if (dif.clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out got=%b exp=0", dif.clk_out); end
    checks++; if (dif.div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", dif.div_busy); end
    checks++; if (dif.div_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", dif.div_err); end
  endtask

  task automatic test_div10();
    rst = 1'b0;
    dif.en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      checks++; if (dif.tick !== ((k % 10) == 0)) begin errors++; $display("FAIL div10_tick k=%0d got=%b exp=%b", k, dif.tick, (k % 10) == 0); end
      checks++; if (dif.clk_out !== ((k % 10) >= 5)) begin errors++; $display("FAIL div10_clk k=%0d got=%b exp=%b", k, dif.clk_out, (k % 10) >= 5); end
    end
  endtask

  task automatic test_load7();
    step(); step(); step();
    dif.div_load = 1'b1; dif.div_val = 16'd7;
    step();
    dif.div_load = 1'b0;
    checks++; if (dif.div_busy !== 1'b1) begin errors++; $display("FAIL load7_busy_set got=%b exp=1", dif.div_busy); end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (dif.tick !== (k == 6)) begin errors++; $display("FAIL load7_old_tick k=%0d got=%b exp=%b", k, dif.tick, k == 6); end
      checks++; if (dif.div_busy !== (k < 6)) begin errors++; $display("FAIL load7_busy k=%0d got=%b exp=%b", k, dif.div_busy, k < 6); end
    end
    for (int k = 1; k <= 14; k++) begin
      step();
      checks++; if (dif.tick !== ((k % 7) == 0)) begin errors++; $display("FAIL load7_tick k=%0d got=%b exp=%b", k, dif.tick, (k % 7) == 0); end
      checks++; if (dif.clk_out !== ((k % 7) >= 4)) begin errors++; $display("FAIL load7_clk k=%0d got=%b exp=%b", k, dif.clk_out, (k % 7) >= 4); end
    end
    dif.div_load = 1'b1; dif.div_val = 16'd10;
    step();
    dif.div_load = 1'b0; dif.sync_clr = 1'b1;
    step();
    dif.sync_clr = 1'b0;
  endtask

  task automatic test_load_zero();
    step(); step();
    dif.div_load = 1'b1; dif.div_val = 16'd0;
    step();
    dif.div_load = 1'b0;
    checks++; if (dif.div_err !== 1'b1) begin errors++; $display("FAIL zero_err_pulse got=%b exp=1", dif.div_err); end
    checks++; if (dif.div_busy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", dif.div_busy); end
    step();
    checks++; if (dif.div_err !== 1'b0) begin errors++; $display("FAIL zero_err_clear got=%b exp=0", dif.div_err); end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (dif.tick !== (k == 6)) begin errors++; $display("FAIL zero_period k=%0d got=%b exp=%b", k, dif.tick, k == 6); end
    end
    dif.div_load = 1'b1; dif.div_val = 16'd5;
    step();
    dif.div_val = 16'd0;
    step();
    dif.div_load = 1'b0;
    checks++; if (dif.div_err !== 1'b1) begin errors++; $display("FAIL zero_pend_err got=%b exp=1", dif.div_err); end
    checks++; if (dif.div_busy !== 1'b1) begin errors++; $display("FAIL zero_pend_kept got=%b exp=1", dif.div_busy); end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (dif.tick !== (k == 8)) begin errors++; $display("FAIL zero_pend_tick k=%0d got=%b exp=%b", k, dif.tick, k == 8); end
    end
    checks++; if (dif.div_busy !== 1'b0) begin errors++; $display("FAIL zero_pend_applied got=%b exp=0", dif.div_busy); end
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (dif.tick !== (k == 5)) begin errors++; $display("FAIL div5_tick k=%0d got=%b exp=%b", k, dif.tick, k == 5); end
      checks++; if (dif.clk_out !== ((k % 5) >= 3)) begin errors++; $display("FAIL div5_clk k=%0d got=%b exp=%b", k, dif.clk_out, (k % 5) >= 3); end
    end
    dif.div_load = 1'b1; dif.div_val = 16'd10;
    step();
    dif.div_load = 1'b0; dif.sync_clr = 1'b1;
    step();
    dif.sync_clr = 1'b0;
  endtask

  task automatic test_enable();
    for (int k = 0; k < 6; k++) step();
    dif.en = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++; if (dif.tick !== 1'b0) begin errors++; $display("FAIL en_hold_tick k=%0d got=%b exp=0", k, dif.tick); end
      checks++; if (dif.clk_out !== 1'b1) begin errors++; $display("FAIL en_hold_clk k=%0d got=%b exp=1", k, dif.clk_out); end
    end
    dif.en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (dif.tick !== (k == 4)) begin errors++; $display("FAIL en_resume k=%0d got=%b exp=%b", k, dif.tick, k == 4); end
    end
    step(); step();
    dif.en = 1'b0; dif.div_load = 1'b1; dif.div_val = 16'd4;
    step();
    dif.div_load = 1'b0;
    checks++; if (dif.div_busy !== 1'b1) begin errors++; $display("FAIL en_load_busy got=%b exp=1", dif.div_busy); end
    step();
    checks++; if (dif.div_busy !== 1'b0) begin errors++; $display("FAIL en_load_applied got=%b exp=0", dif.div_busy); end
    dif.en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (dif.tick !== ((k % 4) == 0)) begin errors++; $display("FAIL div4_tick k=%0d got=%b exp=%b", k, dif.tick, (k % 4) == 0); end
      checks++; if (dif.clk_out !== ((k % 4) >= 2)) begin errors++; $display("FAIL div4_clk k=%0d got=%b exp=%b", k, dif.clk_out, (k % 4) >= 2); end
    end
    dif.en = 1'b0; dif.div_load = 1'b1; dif.div_val = 16'd10;
    step();
    dif.div_load = 1'b0;
    step();
    dif.en = 1'b1;
  endtask

  task automatic test_sync_clr();
    for (int k = 0; k < 6; k++) step();
    checks++; if (dif.clk_out !== 1'b1) begin errors++; $display("FAIL sclr_pre_clk got=%b exp=1", dif.clk_out); end
    dif.sync_clr = 1'b1;
    step();
    dif.sync_clr = 1'b0;
    checks++; if (dif.clk_out !== 1'b0) begin errors++; $display("FAIL sclr_clk got=%b exp=0", dif.clk_out); end
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (dif.tick !== (k == 10)) begin errors++; $display("FAIL sclr_tick k=%0d got=%b exp=%b", k, dif.tick, k == 10); end
      checks++; if (dif.clk_out !== ((k % 10) >= 5)) begin errors++; $display("FAIL sclr_wave k=%0d got=%b exp=%b", k, dif.clk_out, (k % 10) >= 5); end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) step();
    dif.div_load = 1'b1; dif.div_val = 16'd7;
    step();
    dif.div_load = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (dif.div_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", dif.div_busy); end
    checks++; if (dif.clk_out !== 1'b0) begin errors++; $display("FAIL rstmid_clk got=%b exp=0", dif.clk_out); end
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (dif.tick !== (k == 10)) begin errors++; $display("FAIL rstmid_tick k=%0d got=%b exp=%b", k, dif.tick, k == 10); end
    end
  endtask

  task automatic test_back_to_back();
    dif.div_load = 1'b1; dif.div_val = 16'd3;
    step();
    dif.div_val = 16'd6;
    step();
    dif.div_load = 1'b0;
    checks++; if (dif.div_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", dif.div_busy); end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (dif.tick !== (k == 8)) begin errors++; $display("FAIL b2b_old_tick k=%0d got=%b exp=%b", k, dif.tick, k == 8); end
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++; if (dif.tick !== ((k % 6) == 0)) begin errors++; $display("FAIL b2b_tick k=%0d got=%b exp=%b", k, dif.tick, (k % 6) == 0); end
      checks++; if (dif.clk_out !== ((k % 6) >= 3)) begin errors++; $display("FAIL b2b_clk k=%0d got=%b exp=%b", k, dif.clk_out, (k % 6) >= 3); end
    end
  endtask

  task automatic test_div1();
    dif.div_load = 1'b1; dif.div_val = 16'd1;
    step();
    dif.div_load = 1'b0; dif.sync_clr = 1'b1;
    step();
    dif.sync_clr = 1'b0;
    checks++; if (dif.tick !== 1'b0) begin errors++; $display("FAIL div1_clr_tick got=%b exp=0", dif.tick); end
    checks++; if (dif.div_busy !== 1'b0) begin errors++; $display("FAIL div1_busy got=%b exp=0", dif.div_busy); end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (dif.tick !== 1'b1) begin errors++; $display("FAIL div1_tick k=%0d got=%b exp=1", k, dif.tick); end
      checks++; if (dif.clk_out !== 1'b0) begin errors++; $display("FAIL div1_clk k=%0d got=%b exp=0", k, dif.clk_out); end
    end
  endtask

  initial begin
    test_reset();
    test_div10();
    test_load7();
    test_load_zero();
    test_enable();
    test_sync_clr();
    test_reset_mid();
    test_back_to_back();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
